// File: rtl/inout_pkg.sv
// Shared types for the inout channel bank: channel address type and pulse-sequencer states.
package inout_pkg;

  localparam int unsigned CHAN_ADDR_W = 9;

  typedef logic [CHAN_ADDR_W-1:0] chan_addr_t;

  typedef enum logic {
    PS_IDLE,
    PS_RUN
  } pulse_state_t;

endpackage

// File: rtl/chan_pulse_seq.sv
// Pulse-train sequencer: a loaded signed magnitude becomes counted plus/minus pulses,
// one per rate strobe.
module chan_pulse_seq
  import inout_pkg::*;
#(
  parameter int unsigned CW = 14
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          load,
  input  logic [CW-1:0] load_mag,
  input  logic          load_dir,
  input  logic          stb,
  output logic          pls_p,
  output logic          pls_m,
  output logic          busy,
  output logic [CW-1:0] cnt,
  output logic          dir
);

  pulse_state_t  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dir_q, dir_d;
  logic          pls_p_q, pls_p_d;
  logic          pls_m_q, pls_m_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= PS_IDLE;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      pls_p_q <= 1'b0;
      pls_m_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      pls_p_q <= pls_p_d;
      pls_m_q <= pls_m_d;
    end
  end

  // Priority: abort, then load (a load swallows a coincident strobe), then strobe.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    pls_p_d = 1'b0;
    pls_m_d = 1'b0;
    if (clr) begin
      state_d = PS_IDLE;
      cnt_d   = '0;
      dir_d   = 1'b0;
    end else if (load) begin
      cnt_d   = load_mag;
      dir_d   = load_dir;
      state_d = (load_mag != '0) ? PS_RUN : PS_IDLE;
    end else if (state_q == PS_RUN && stb) begin
      pls_p_d = ~dir_q;
      pls_m_d = dir_q;
      cnt_d   = cnt_q - 1'b1;
      if (cnt_q == CW'(1)) begin
        state_d = PS_IDLE;
      end
    end
  end

  assign pls_p = pls_p_q;
  assign pls_m = pls_m_q;
  assign busy  = (state_q == PS_RUN);
  assign cnt   = cnt_q;
  assign dir   = dir_q;

endmodule

// File: rtl/inout_chan_bank.sv
// Bank of addressable output-channel registers with registered active-low readback
// and an optional pulse-train channel.
module inout_chan_bank
  import inout_pkg::*;
#(
  parameter int unsigned              WIDTH      = 15,
  parameter int unsigned              NCHAN      = 4,
  parameter int unsigned              ADDR_W     = 9,
  parameter logic [NCHAN*ADDR_W-1:0]  CHAN_ADDRS = {9'o35, 9'o34, 9'o14, 9'o13},
  parameter logic [NCHAN-1:0]         GOJAM_MASK = 4'b1111,
  parameter bit                       PULSE_EN   = 1'b1,
  parameter int unsigned              PULSE_IDX  = 1
) (
  input  logic                   SIM_CLK,
  input  logic                   SIM_RST,
  input  logic                   GOJAM,
  input  logic [ADDR_W-1:0]      CHAN_ADDR,
  input  logic                   RCHG_n,
  input  logic                   WCHG_n,
  input  logic                   CCHG_n,
  input  logic [WIDTH-1:0]       WL,
  input  logic [NCHAN*WIDTH-1:0] CHIN,
  output logic [WIDTH-1:0]       CHOR_n,
  output logic [NCHAN*WIDTH-1:0] CH,
  input  logic                   PLS_STB,
  output logic                   PLS_P,
  output logic                   PLS_M,
  output logic                   PLS_BUSY
);

  localparam int unsigned SEL_W = (NCHAN > 1) ? $clog2(NCHAN) : 1;

  logic [NCHAN-1:0][WIDTH-1:0] reg_q, reg_d;
  logic [WIDTH-1:0]            chor_q, chor_d;
  logic [SEL_W-1:0]            sel;
  logic                        hit_any;
  logic                        is_pls_sel;
  logic [WIDTH-1:0]            rd_word;
  logic [WIDTH-2:0]            seq_cnt;
  logic                        seq_dir;
  logic                        seq_load;
  logic                        seq_clr;

  always_comb begin
    sel     = '0;
    hit_any = 1'b0;
    for (int unsigned i = 0; i < NCHAN; i++) begin
      if (!hit_any && CHAN_ADDR == CHAN_ADDRS[i*ADDR_W +: ADDR_W]) begin
        sel     = SEL_W'(i);
        hit_any = 1'b1;
      end
    end
  end

  // The pulse channel reads back live sequencer state rather than the written word.
  always_comb begin
    is_pls_sel = PULSE_EN && hit_any && (sel == SEL_W'(PULSE_IDX));
    rd_word    = is_pls_sel ? {seq_dir, seq_cnt} : reg_q[sel];
    seq_load   = !GOJAM && is_pls_sel && !WCHG_n;
    seq_clr    = GOJAM || (is_pls_sel && WCHG_n && !CCHG_n);
  end

  always_comb begin
    reg_d  = reg_q;
    chor_d = '1;
    if (GOJAM) begin
      for (int unsigned i = 0; i < NCHAN; i++) begin
        if (GOJAM_MASK[i]) begin
          reg_d[i] = '0;
        end
      end
    end else if (hit_any) begin
      if (!WCHG_n) begin
        reg_d[sel] = WL;
      end else if (!CCHG_n) begin
        reg_d[sel] = '0;
      end
      if (!RCHG_n) begin
        chor_d = ~(rd_word | CHIN[sel*WIDTH +: WIDTH]);
      end
    end
  end

  always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
    if (SIM_RST) begin
      reg_q  <= '0;
      chor_q <= '1;
    end else begin
      reg_q  <= reg_d;
      chor_q <= chor_d;
    end
  end

  assign CH     = reg_q;
  assign CHOR_n = chor_q;

  if (PULSE_EN) begin : g_pulse
    chan_pulse_seq #(
      .CW(WIDTH-1)
    ) u_seq (
      .clk     (SIM_CLK),
      .rst     (SIM_RST),
      .clr     (seq_clr),
      .load    (seq_load),
      .load_mag(WL[WIDTH-2:0]),
      .load_dir(WL[WIDTH-1]),
      .stb     (PLS_STB),
      .pls_p   (PLS_P),
      .pls_m   (PLS_M),
      .busy    (PLS_BUSY),
      .cnt     (seq_cnt),
      .dir     (seq_dir)
    );
  end else begin : g_no_pulse
    assign PLS_P    = 1'b0;
    assign PLS_M    = 1'b0;
    assign PLS_BUSY = 1'b0;
    assign seq_cnt  = '0;
    assign seq_dir  = 1'b0;
  end

endmodule
